// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-stage register hazard tracker with bypass select and load-use stall
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_kill,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       fwd_sel_A,
    output logic [1:0]       fwd_sel_B,
    output logic [CNT_W-1:0] stall_count
);
    localparam int         NR     = 1 << AW;
    localparam logic [1:0] LD_LAT = 2'(LOAD_LAT);

    logic [1:0]    age [NR];
    logic [NR-1:0] ld;

    logic [1:0] age_a, age_b;
    logic       haz_a, haz_b;
    logic       ld_use_a, ld_use_b;
    logic       wr_hit;

    always_comb begin
        age_a    = age[id_rs];
        age_b    = age[id_rt];
        haz_a    = id_use_rs && (id_rs != '0) && (age_a != 2'd0);
        haz_b    = id_use_rt && (id_rt != '0) && (age_b != 2'd0);
        ld_use_a = haz_a && ld[id_rs] && (age_a <= LD_LAT);
        ld_use_b = haz_b && ld[id_rt] && (age_b <= LD_LAT);
        fwd_sel_A = haz_a ? age_a : 2'b00;
        fwd_sel_B = haz_b ? age_b : 2'b00;
        stall     = id_valid && !id_kill && (ld_use_a || ld_use_b);
        issue     = id_valid && !id_kill && !stall;
        wr_hit    = issue && id_wr_en && (id_rd != '0);
    end

    // A new producer overrides the advancing entry so the newest write wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NR; r++) begin
                age[r] <= 2'd0;
            end
            ld <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (wr_hit && (id_rd == AW'(r))) begin
                    age[r] <= 2'd1;
                    ld[r]  <= id_is_load;
                end else if (age[r] == 2'd3) begin
                    age[r] <= 2'd0;
                    ld[r]  <= 1'b0;
                end else if (age[r] != 2'd0) begin
                    age[r] <= age[r] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
